// File: rtl/uart_tx_axis.sv
// 8N1 UART transmitter (LSB first) fed by an AXI-Stream-style byte port through a small FIFO.
// Back-to-back bytes are sent with no idle gap between stop bit and next start bit.
module uart_tx_axis #(
    parameter int CLKS_PER_BIT = 4167,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          axis_clk,
    input  logic                          axis_rst_n,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    input  logic [7:0]                    s_tdata,
    output logic                          tx,
    output logic                          tx_oeb,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [1:0]                    dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);

    // Handshake: a byte transfers on a rising edge where s_tvalid and s_tready are both 1.
    // s_tready depends only on the registered occupancy, never on a same-cycle pop.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          push;
    logic          pop;
    logic          bit_end;
    logic          fifo_nonempty;

    assign s_tready      = (fifo_level < LW'(FIFO_DEPTH));
    assign push          = s_tvalid & s_tready;
    assign fifo_nonempty = (fifo_level != '0);
    assign bit_end       = (timer == TW'(CLKS_PER_BIT - 1));
    assign pop           = fifo_nonempty & ((state == IDLE) | ((state == STOP) & bit_end));

    assign busy      = (state != IDLE) | fifo_nonempty;
    assign tx_oeb    = 1'b0;
    assign dbg_state = state;

    always_ff @(posedge axis_clk) begin
        if (push) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // tx is set one state ahead so the pad sees a registered, glitch-free level.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state   <= IDLE;
            tx      <= 1'b1;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (fifo_nonempty) begin
                        shift   <= mem[rd_ptr];
                        timer   <= '0;
                        bit_idx <= '0;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        timer <= '0;
                        tx    <= shift[0];
                        state <= DATA;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer   <= '0;
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx <= shift[1];
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (fifo_nonempty) begin
                            shift   <= mem[rd_ptr];
                            bit_idx <= '0;
                            tx      <= 1'b0;
                            state   <= START;
                        end else begin
                            tx    <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_axis.sv
// Directed bench for uart_tx_axis: a serial-line decoder pops an expected-byte queue
// filled by the driver, plus timing checks on frame lengths, backpressure and reset.
module tb_uart_tx_axis;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          axis_clk = 1'b0;
    logic          axis_rst_n;
    logic          s_tvalid;
    logic          s_tready;
    logic [7:0]    s_tdata;
    logic          tx;
    logic          tx_oeb;
    logic          busy;
    logic [LW-1:0] fifo_level;
    logic [1:0]    dbg_state;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;
    int unsigned last_hs = 0;
    logic [7:0]  exp_q[$];
    int unsigned start_q[$];
    int          rx_count = 0;

    logic        rx_busy = 1'b0;
    int          rx_cnt = 0;
    int          rx_bit = 0;
    logic [7:0]  rx_byte = '0;
    logic [7:0]  rx_exp = '0;

    uart_tx_axis #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tdata    (s_tdata),
        .tx         (tx),
        .tx_oeb     (tx_oeb),
        .busy       (busy),
        .fifo_level (fifo_level),
        .dbg_state  (dbg_state)
    );

    always #5 axis_clk = ~axis_clk;
    always @(posedge axis_clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Serial decoder: samples mid-bit on the falling clock edge, pops the scoreboard at mid-stop.
    always @(negedge axis_clk) begin
        if (!axis_rst_n) begin
            rx_busy = 1'b0;
        end else begin
            if (!rx_busy && tx === 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
                start_q.push_back(cyc);
            end else if (rx_busy) begin
                rx_cnt++;
            end
            if (rx_busy && (rx_cnt % CPB) == CPB / 2) begin
                rx_bit = rx_cnt / CPB;
                if (rx_bit == 0) begin
                    check("rx_start_bit", tx, 1'b0);
                end else if (rx_bit <= 8) begin
                    rx_byte[rx_bit-1] = tx;
                end else begin
                    check("rx_stop_bit", tx, 1'b1);
                    rx_busy = 1'b0;
                    rx_count++;
                    check("rx_byte_expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        rx_exp = exp_q.pop_front();
                        check("rx_byte", rx_byte, rx_exp);
                    end
                end
            end
        end
    end

    // Called on a falling edge; returns on the falling edge after the handshake.
    task automatic push(input logic [7:0] b);
        int guard = 0;
        s_tdata  = b;
        s_tvalid = 1'b1;
        while (s_tready !== 1'b1 && guard < 2000) begin
            @(negedge axis_clk);
            guard++;
        end
        check("push_ready_wait", guard < 2000, 1'b1);
        @(posedge axis_clk);
        last_hs = cyc;
        exp_q.push_back(b);
        @(negedge axis_clk);
    endtask

    task automatic wait_drain(input string tag);
        int guard = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && guard < 5000) begin
            @(negedge axis_clk);
            guard++;
        end
        check(tag, guard < 5000, 1'b1);
    endtask

    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (tx === lvl && busy === 1'b1 && n < 500) begin
            n++;
            @(negedge axis_clk);
        end
    endtask

    initial begin
        logic [7:0]  byte_v;
        logic        exp_bit;
        int          wave_bad;
        int unsigned hs_first;
        int          rx_base;
        int          n;
        int          guard;
        int          n_acc;
        int          bad;

        // clock/reset
        axis_rst_n = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata    = 8'h00;
        repeat (3) @(negedge axis_clk);
        check("rst_tx", tx, 1'b1);
        check("rst_oeb", tx_oeb, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_level", fifo_level, 0);
        check("rst_state", dbg_state, 2'd0);
        axis_rst_n = 1'b1;
        @(negedge axis_clk);
        check("rst_tready", s_tready, 1'b1);
        check("idle_tx", tx, 1'b1);

        // single byte: exact waveform and busy timing
        byte_v = 8'hA5;
        rx_base = rx_count;
        push(byte_v);
        s_tvalid = 1'b0;
        check("a5_tx_before_pop", tx, 1'b1);
        wave_bad = 0;
        for (int i = 0; i < 10 * CPB; i++) begin
            @(negedge axis_clk);
            if (i / CPB == 0)      exp_bit = 1'b0;
            else if (i / CPB == 9) exp_bit = 1'b1;
            else                   exp_bit = byte_v[i / CPB - 1];
            if (tx !== exp_bit) wave_bad++;
        end
        check("a5_waveform", wave_bad, 0);
        check("a5_busy_last_cycle", busy, 1'b1);
        @(negedge axis_clk);
        check("a5_busy_fall", busy, 1'b0);
        check("a5_rx_count", rx_count - rx_base, 1);

        // burst with backpressure
        start_q.delete();
        rx_base = rx_count;
        push(8'h00);
        hs_first = last_hs;
        for (int i = 1; i < 5; i++) push(8'(i));
        check("burst_consecutive", last_hs - hs_first, 4);
        check("burst_tready_low", s_tready, 1'b0);
        check("burst_level_full", fifo_level, DEPTH);
        push(8'h05);
        s_tvalid = 1'b0;
        wait_drain("burst_drain");
        check("burst_frames", rx_count - rx_base, 6);
        check("burst_starts", start_q.size(), 6);
        if (start_q.size() > 0) check("burst_span", cyc - start_q[0], 6 * 10 * CPB);

        // data extremes: run lengths on the line
        push(8'h00);
        push(8'hFF);
        s_tvalid = 1'b0;
        guard = 0;
        while (tx !== 1'b0 && guard < 100) begin
            @(negedge axis_clk);
            guard++;
        end
        check("ext_start_seen", guard < 100, 1'b1);
        run_len(1'b0, n);
        check("ext_low_run", n, 9 * CPB);
        run_len(1'b1, n);
        check("ext_stop_run", n, CPB);
        run_len(1'b0, n);
        check("ext_start2_run", n, CPB);
        run_len(1'b1, n);
        check("ext_high_run", n, 9 * CPB);
        wait_drain("ext_drain");

        // reset during bit 3 of 0x3C with two bytes queued
        start_q.delete();
        rx_base = rx_count;
        push(8'h3C);
        push(8'h11);
        push(8'h22);
        s_tvalid = 1'b0;
        guard = 0;
        while (start_q.size() == 0 && guard < 100) begin
            @(negedge axis_clk);
            guard++;
        end
        check("rstmid_start_seen", start_q.size(), 1);
        if (start_q.size() > 0) begin
            while (cyc < start_q[0] + 4 * CPB + 3 && guard < 200) begin
                @(negedge axis_clk);
                guard++;
            end
        end
        check("rstmid_pre_level", fifo_level, 2);
        #2;
        axis_rst_n = 1'b0;
        #1;
        check("rstmid_tx", tx, 1'b1);
        check("rstmid_level", fifo_level, 0);
        check("rstmid_busy", busy, 1'b0);
        exp_q.delete();
        repeat (2) @(negedge axis_clk);
        axis_rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge axis_clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("rstmid_quiet", bad, 0);
        check("rstmid_no_rx", rx_count - rx_base, 0);
        push(8'h42);
        s_tvalid = 1'b0;
        wait_drain("rstmid_drain");
        check("rstmid_new_byte", rx_count - rx_base, 1);

        // stall hold: s_tdata changes every cycle while the FIFO is full
        rx_base = rx_count;
        for (int i = 0; i < 5; i++) push(8'($urandom_range(0, 255)));
        n_acc = 0;
        guard = 0;
        while (n_acc < 3 && guard < 2000) begin
            s_tdata  = 8'($urandom_range(0, 255));
            s_tvalid = 1'b1;
            if (s_tready === 1'b1) begin
                @(posedge axis_clk);
                exp_q.push_back(s_tdata);
                n_acc++;
            end
            @(negedge axis_clk);
            guard++;
        end
        s_tvalid = 1'b0;
        check("stall_accepts", n_acc, 3);
        wait_drain("stall_drain");
        check("stall_frames", rx_count - rx_base, 8);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_axis.md
# uart_tx_axis

Byte-serial UART transmitter (8N1, LSB first) for the user project area. It accepts bytes on an AXI-Stream-style slave port and buffers them in a small FIFO. It drives them onto a user GPIO pad (mprj_io[6]), where the testbench UART receiver decodes them. This gives firmware and user logic a print path that is independent of the management-core UART.

## Interface
- CLKS_PER_BIT, 4167, clock cycles per serial bit (4167 ≈ 40 MHz / 9600 baud); legal range ≥ 2.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, ≥ 2.

- axis_clk  in  1  single clock; all logic is on its rising edge.
- axis_rst_n  in  1  reset, asynchronous assert, active-low.
- s_tvalid  in  1  byte offered.
- s_tready  out  1  FIFO can accept.
- s_tdata  in  8  byte to send.
- tx  out  1  serial line; idle high.
- tx_oeb  out  1  pad output-enable, active-low; 0 whenever out of reset.
- busy  out  1  FIFO non-empty or frame in progress.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Push: a byte is written when s_tvalid & s_tready at a rising edge. s_tready = (fifo_level < FIFO_DEPTH), combinational from the registered count only. It never depends on a same-cycle pop, so a full FIFO refuses a byte even while it is popping.
- FIFO: circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH, plus an occupancy counter. A simultaneous push and pop leaves the count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - tx=1.
    - If the FIFO is non-empty: pop into an 8-bit shift register, clear the bit timer and bit index, and go to START.
  - START:
    - tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA:
    - tx=shift[0]. Each bit is held CLKS_PER_BIT cycles.
    - At the end of each bit: shift right and increment the index (0..7).
    - After bit 7, go to STOP.
  - STOP:
    - tx=1 for CLKS_PER_BIT cycles.
    - At the end: if the FIFO is non-empty, pop and go to START on the same edge (no idle gap). Otherwise go to IDLE.
- Bit timer counts 0..CLKS_PER_BIT-1. The bit ends on the edge where timer == CLKS_PER_BIT-1.
- tx is a registered output (glitch-free pad drive).
- busy = (state != IDLE) | (fifo_level != 0).
- The frame is fixed: 1 start bit, 8 data bits, 1 stop bit, no parity.

## Timing
- Reset values (asynchronous):
  - tx=1, tx_oeb=0, busy=0, fifo_level=0.
  - s_tready=1 as soon as reset deasserts.
  - state=IDLE; pointers, timer and index = 0.
- Latency: a byte pushed into an empty, idle block at edge N is popped at edge N+1, and tx falls after edge N+1.
- Frame length: exactly 10·CLKS_PER_BIT cycles from the tx falling edge to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the edge right after the last stop-bit cycle. N queued bytes occupy exactly 10·N·CLKS_PER_BIT cycles.
- Capacity: while a frame is transmitting, FIFO_DEPTH further bytes are accepted before s_tready drops.
- Reset mid-frame: tx returns high immediately (asynchronous), and FIFO contents and the partial frame are discarded. No byte is emitted after release until a new push.
- s_tdata is sampled only on a handshake edge. Changes while s_tready=0 have no effect.

## Test plan
All scenarios use CLKS_PER_BIT=8 and FIFO_DEPTH=4.
- Single byte: push 0xA5 at edge N.
  - tx=0 for cycles N+1..N+8, then the bit sequence 1,0,1,0,0,1,0,1 (8 cycles each), then 1 for 8 cycles.
  - busy falls 80 cycles after N+1.
- Burst with backpressure: hold s_tvalid with bytes 0x00..0x05.
  - The first 5 bytes are accepted on consecutive edges, then s_tready=0 and fifo_level=4.
  - The remaining bytes are accepted one per frame.
  - All 6 frames are decoded in order, contiguous, totalling 480 cycles.
- Data extremes: push 0x00 then 0xFF.
  - Expect a 72-cycle low run (start bit + data bits), then an 8-cycle stop bit, then a 72-cycle high run after the start bit.
  - Frame boundaries are exact.
- Reset mid-frame: assert axis_rst_n=0 during bit 3 of 0x3C, with 2 more bytes queued.
  - tx=1 immediately, fifo_level=0, busy=0.
  - After release: no activity. A new push of 0x42 transmits correctly.
- Stall hold: while full, change s_tdata every cycle with s_tvalid=1.
  - Only the value present on the edge where s_tready=1 is transmitted.
  - No duplicates or losses, checked by the scoreboard.
- System check: run at the default CLKS_PER_BIT in the Caravel testbench, with firmware writing the string "OK\n" through the port.
  - The testbench UART prints "OK".
